// File: rtl/analog_in_filter_pkg.sv
// Shared analog defaults and saturating helpers reused across analog blocks.
package analog_in_filter_pkg;

  localparam int ANA_BITS       = 16;
  localparam int ANA_LOG2_DEPTH = 3;
  localparam int ANA_HYST       = 64;

  // a - b, clamped at 0
  function automatic logic [31:0] sat0(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  // a + b, clamped at maxv
  function automatic logic [31:0] satmax(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] maxv);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, maxv}) ? maxv : s[31:0];
  endfunction

endpackage

// File: rtl/analog_in_filter_ring_buffer.sv
// DEPTH x BITS sample ring; the entry at the write pointer is the oldest one.
module filt_ring_buffer
  import analog_in_filter_pkg::*;
#(
  parameter int BITS       = ANA_BITS,
  parameter int LOG2_DEPTH = ANA_LOG2_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  output logic [BITS-1:0] rd_old
);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [BITS-1:0]       r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;

  // Storage is intentionally not reset; the parent's count masks stale data.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_wr_ptr <= '0;
    else if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  assign rd_old = r_mem[r_wr_ptr];

endmodule

// File: rtl/analog_in_filter.sv
// Moving-average filter with hysteretic hi/lo alarms.
// Optional min/max tracking of the filtered value under ANALOG_FILT_MINMAX_EN.
module analog_in_filter
  import analog_in_filter_pkg::*;
#(
  parameter int BITS       = ANA_BITS,
  parameter int LOG2_DEPTH = ANA_LOG2_DEPTH,
  parameter int HYST       = ANA_HYST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic [BITS-1:0] sample_in,
  input  logic [BITS-1:0] hi_limit,
  input  logic [BITS-1:0] lo_limit,
  output logic [BITS-1:0] filt_out,
  output logic            filt_valid,
  output logic            primed,
  output logic            alarm_hi,
  output logic            alarm_lo
`ifdef ANALOG_FILT_MINMAX_EN
  ,
  input  logic            minmax_clr,
  output logic [BITS-1:0] min_out,
  output logic [BITS-1:0] max_out
`endif
);
  localparam int                AW       = BITS + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] CNT_FULL = (LOG2_DEPTH + 1)'(1 << LOG2_DEPTH);
  localparam logic [BITS-1:0]   VMAX     = {BITS{1'b1}};

  logic [LOG2_DEPTH:0] r_count;
  logic [AW-1:0]       r_acc;
  logic [BITS-1:0]     r_filt;
  logic                r_fv, r_primed, r_ahi, r_alo;

  logic [BITS-1:0]     w_rd_old, w_old, w_f, w_hi_clr, w_lo_clr;
  logic [AW-1:0]       w_acc_next;
  logic [LOG2_DEPTH:0] w_count_next;
  logic                w_full, w_fv;

  filt_ring_buffer #(.BITS(BITS), .LOG2_DEPTH(LOG2_DEPTH)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (sample_en),
    .wr_data (sample_in),
    .rd_old  (w_rd_old)
  );

  assign w_full       = (r_count == CNT_FULL);
  assign w_old        = w_full ? w_rd_old : '0;
  // Intermediate sum may wrap, but the final value always fits in AW bits.
  assign w_acc_next   = r_acc + AW'(sample_in) - AW'(w_old);
  assign w_count_next = w_full ? r_count : r_count + 1'b1;
  assign w_f          = BITS'(w_acc_next >> LOG2_DEPTH);
  assign w_fv         = sample_en && (w_count_next == CNT_FULL);

  assign w_hi_clr = BITS'(sat0(32'(hi_limit), 32'(HYST)));
  assign w_lo_clr = BITS'(satmax(32'(lo_limit), 32'(HYST), 32'(VMAX)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_filt   <= '0;
      r_fv     <= 1'b0;
      r_primed <= 1'b0;
      r_ahi    <= 1'b0;
      r_alo    <= 1'b0;
    end else begin
      r_fv <= w_fv;
      if (sample_en) begin
        r_count  <= w_count_next;
        r_acc    <= w_acc_next;
        r_filt   <= w_f;
        r_primed <= (w_count_next == CNT_FULL);
      end
      // Set and clear thresholds are disjoint, so set-first ordering is safe.
      if (w_fv) begin
        if (w_f >= hi_limit)      r_ahi <= 1'b1;
        else if (w_f < w_hi_clr)  r_ahi <= 1'b0;
        if (w_f <= lo_limit)      r_alo <= 1'b1;
        else if (w_f > w_lo_clr)  r_alo <= 1'b0;
      end
    end
  end

  assign filt_out   = r_filt;
  assign filt_valid = r_fv;
  assign primed     = r_primed;
  assign alarm_hi   = r_ahi;
  assign alarm_lo   = r_alo;

`ifdef ANALOG_FILT_MINMAX_EN
  logic [BITS-1:0] r_min, r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min <= VMAX;
      r_max <= '0;
    end else if (minmax_clr) begin
      r_min <= w_fv ? w_f : VMAX;
      r_max <= w_fv ? w_f : '0;
    end else if (w_fv) begin
      if (w_f < r_min) r_min <= w_f;
      if (w_f > r_max) r_max <= w_f;
    end
  end

  assign min_out = r_min;
  assign max_out = r_max;
`endif

endmodule

// File: doc/analog_in_filter.md
Name: analog_in_filter

Overview:
- Downstream consumer of the analog I/O port stage. It takes the raw BITS-wide unsigned sample from that stage's data_out each time a read is strobed.
- Produces a moving-average value over a 2^LOG2_DEPTH window, plus high/low limit alarms with hysteresis.
- Feeds the PLC logic core with a filtered analog value and alarm flags.

Parameters:
- BITS, 16, sample and limit width (unsigned).
- LOG2_DEPTH, 3, log2 of the averaging window; DEPTH = 2^LOG2_DEPTH = 8.
- HYST, 64, alarm hysteresis in LSBs.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- sample_en  input  1  one-cycle strobe; sample_in is valid this cycle.
- sample_in  input  BITS  raw sample from the analog I/O data_out.
- hi_limit  input  BITS  high alarm threshold, sampled at evaluation.
- lo_limit  input  BITS  low alarm threshold, sampled at evaluation.
- filt_out  output  BITS  filtered value.
- filt_valid  output  1  one-cycle pulse when filt_out is updated and the window is full.
- primed  output  1  window holds DEPTH samples.
- alarm_hi  output  1  high alarm, sticky with hysteresis.
- alarm_lo  output  1  low alarm, sticky with hysteresis.

Behaviour:
- Reset:
  - Clears wr_ptr, count, acc, filt_out, filt_valid, primed, alarm_hi and alarm_lo to 0.
  - Buffer contents are don't-care, because count masks them.
  - rst wins over a simultaneous sample_en. Reset mid-window discards all history.
- Accumulator:
  - acc is BITS+LOG2_DEPTH bits wide and can never overflow.
  - On sample_en: old = (count==DEPTH) ? buf[wr_ptr] : 0; acc_next = acc + sample_in - old.
  - Same edge: buf[wr_ptr] <= sample_in; wr_ptr <= wr_ptr+1 (wraps mod DEPTH); count <= min(count+1, DEPTH).
- Output:
  - filt_out <= acc_next >> LOG2_DEPTH (truncating) on every sample_en, including during warm-up.
  - filt_valid <= sample_en && (count_next==DEPTH); otherwise 0. It is never high two cycles in a row unless sample_en is.
  - Latency: filt_out/filt_valid are visible the cycle after sample_en.
- primed = (count==DEPTH), registered. It rises together with the first filt_valid.
- Alarms:
  - Evaluated only on edges where filt_valid is set, using the new filtered value F and the current limits.
  - alarm_hi: set if F >= hi_limit; cleared if F < sat0(hi_limit - HYST); otherwise hold.
  - alarm_lo: set if F <= lo_limit; cleared if F > satmax(lo_limit + HYST); otherwise hold.
  - sat0 clamps at 0 and satmax clamps at 2^BITS-1. If the clamped clear threshold is unreachable, the alarm stays set until reset.
  - Both alarms may be set at once when lo_limit >= hi_limit. No priority applies.
- No backpressure. Samples arriving on back-to-back cycles are each accepted.

Optional Feature:
- Macro: ANALOG_FILT_MINMAX_EN.
- Defined: adds ports minmax_clr (input, 1), min_out (output, BITS) and max_out (output, BITS).
  - On each filt_valid, min_out/max_out track the extremes of F.
  - minmax_clr loads min_out=2^BITS-1 and max_out=0. If minmax_clr and filt_valid occur in the same cycle, both outputs load F.
  - Reset behaves like a clear.
- Undefined: none of these ports or registers exist; the rest of the behaviour is identical.

Decomposition:
- Shared analog package/include holds:
  - default BITS=16;
  - default LOG2_DEPTH and HYST;
  - the sat0/satmax helper functions, reused by other analog blocks.
- One sub-module, filt_ring_buffer:
  - DEPTH x BITS storage with write pointer;
  - combinational read of the oldest entry at wr_ptr;
  - no reset on the storage array.

Test Plan:
- Warm-up: reset, then 8 strobes of 1000 with gaps -> filt_valid/primed first high the cycle after the 8th strobe; filt_out=1000; no filt_valid on strobes 1-7.
- Step: primed at 1000, then 8 back-to-back strobes of 2000 -> filt_out 1125, 1250, … 2000 on consecutive cycles; filt_valid high for 8 cycles.
- High hysteresis: hi_limit=1500 during the step.
  - alarm_hi sets when F=1500.
  - Then feed 1000s: still set at F=1437, clears at F<1436.
- Low saturation: lo_limit=65500, all samples 65535 x8 -> F=65535 with no accumulator overflow; alarm_lo stays clear.
  - Then lo_limit=65535 -> alarm_lo sets on the next filt_valid and never clears.
- Reset mid-window: 5 strobes, then rst asserted together with sample_en -> all outputs 0; 8 new strobes are needed before filt_valid.
- With ANALOG_FILT_MINMAX_EN, during the step scenario -> min_out=1000, max_out=2000; minmax_clr then one filt_valid -> both outputs equal F.
